// File: rtl/uart_dump_pkg.sv
// Shared types, ASCII constants and sizing helpers for the UART memory dumper.
package uart_dump_pkg;

   // Top-level control states, in the order a dump walks through them.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WAIT_DATA,
      ST_EMIT,
      ST_DONE
   } state_t;

   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_COLON = 8'h3A;
   localparam logic [7:0] ASCII_SPACE = 8'h20;

   // Hex digits needed for an address; the address is zero-extended to a nibble boundary.
   function automatic int addr_digits(input int addr_w);
      return (addr_w + 3) / 4;
   endfunction

   // Hex digits needed for one data word.
   function automatic int data_digits(input int data_w);
      return data_w / 4;
   endfunction

   // Bytes in one data word.
   function automatic int data_bytes(input int data_w);
      return data_w / 8;
   endfunction

   // Uppercase ASCII character for one nibble.
   function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
      if (nib < 4'd10) return 8'h30 + {4'h0, nib};
      else             return 8'h37 + {4'h0, nib};
   endfunction

endpackage

// File: rtl/dump_formatter.sv
// Turns one captured memory word into its byte sequence (raw binary or an
// ASCII hex fragment) and hands the bytes to a valid/ready transmitter.
module dump_formatter
   import uart_dump_pkg::*;
#(
   parameter int ADDR_W     = 17,
   parameter int DATA_W     = 32,
   parameter int BIG_ENDIAN = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [DATA_W-1:0] word,
   input  logic [ADDR_W-1:0] addr,
   input  logic              hex,
   input  logic              prefix,
   input  logic              eol,
   input  logic              uart_ready,
   output logic              uart_valid,
   output logic [7:0]        uart_data,
   output logic              word_done
);

   localparam int ADDR_DIGITS = addr_digits(ADDR_W);
   localparam int DATA_DIGITS = data_digits(DATA_W);
   localparam int DATA_BYTES  = data_bytes(DATA_W);
   localparam int AE_W        = 4 * ADDR_DIGITS;

   logic [DATA_W-1:0] word_q;
   logic [ADDR_W-1:0] addr_q;
   logic              hex_q;
   logic              prefix_q;
   logic              eol_q;
   logic [7:0]        idx_q;
   logic              last_byte;
   logic [7:0]        next_byte;

   // Number of bytes this word produces.
   function automatic int word_len(input logic hx, input logic pfx, input logic le);
      if (!hx) return DATA_BYTES;
      return (pfx ? ADDR_DIGITS + 2 : 0) + DATA_DIGITS + (le ? 2 : 1);
   endfunction

   // Byte at position pos of the sequence for word w at address a.
   function automatic logic [7:0] byte_at(input int pos, input logic [DATA_W-1:0] w,
                                          input logic [ADDR_W-1:0] a, input logic hx,
                                          input logic pfx, input logic le);
      logic [AE_W-1:0] a_ext;
      logic [7:0]      r;
      int              p;
      int              sel;
      a_ext = AE_W'(a);
      p     = pos;
      r     = ASCII_SPACE;
      if (!hx) begin
         sel = (BIG_ENDIAN != 0) ? (DATA_BYTES - 1 - p) : p;
         r   = w[8*sel +: 8];
      end else if (pfx && p < ADDR_DIGITS) begin
         r = nibble_to_ascii(a_ext[4*(ADDR_DIGITS-1-p) +: 4]);
      end else if (pfx && p == ADDR_DIGITS) begin
         r = ASCII_COLON;
      end else if (pfx && p == ADDR_DIGITS + 1) begin
         r = ASCII_SPACE;
      end else begin
         if (pfx) p = p - (ADDR_DIGITS + 2);
         if (p < DATA_DIGITS)       r = nibble_to_ascii(w[4*(DATA_DIGITS-1-p) +: 4]);
         else if (p == DATA_DIGITS) r = le ? ASCII_CR : ASCII_SPACE;
         else                       r = ASCII_LF;
      end
      return r;
   endfunction

   assign last_byte = (int'(idx_q) == word_len(hex_q, prefix_q, eol_q) - 1);
   assign next_byte = byte_at(int'(idx_q) + 1, word_q, addr_q, hex_q, prefix_q, eol_q);
   assign word_done = uart_valid && uart_ready && last_byte;

   // Capture the word and its formatting context when a new word arrives.
   // NOTE: these holding registers carry no reset; they are always loaded before use.
   always_ff @(posedge clk) begin
      if (load) begin
         word_q   <= word;
         addr_q   <= addr;
         hex_q    <= hex;
         prefix_q <= prefix;
         eol_q    <= eol;
      end
   end

   // Byte sequencer: present byte 0 on load, advance one byte per accepted transfer.
   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         uart_valid <= 1'b0;
         uart_data  <= 8'h00;
         idx_q      <= 8'd0;
      end else if (load) begin
         uart_valid <= 1'b1;
         uart_data  <= byte_at(0, word, addr, hex, prefix, eol);
         idx_q      <= 8'd0;
      end else if (uart_valid && uart_ready) begin
         if (last_byte) begin
            uart_valid <= 1'b0;
         end else begin
            idx_q     <= idx_q + 8'd1;
            uart_data <= next_byte;
         end
      end
   end

endmodule

// File: rtl/uart_mem_dump_fmt.sv
// Dumps an inclusive word-address range from an Avalon-MM-style read port to a
// valid/ready UART transmitter, as raw bytes or as ASCII hex lines.
module uart_mem_dump_fmt
   import uart_dump_pkg::*;
#(
   parameter int ADDR_W         = 17,
   parameter int DATA_W         = 32,
   parameter int BIG_ENDIAN     = 1,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] end_addr,
   input  logic              mode_hex,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              mem_waitrequest,
   input  logic              mem_readdatavalid,
   output logic              uart_valid,
   input  logic              uart_ready,
   output logic [7:0]        uart_data
);

   localparam int              LC_W    = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
   localparam logic [LC_W-1:0] LC_LAST = LC_W'(WORDS_PER_LINE - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cur_q, cur_d;
   logic [ADDR_W-1:0] end_q, end_d;
   logic              hex_q, hex_d;
   logic [LC_W-1:0]   line_q, line_d;
   logic              read_q, read_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              is_last;
   logic              load;
   logic              word_done;

   assign is_last  = (cur_q == end_q);
   assign load     = (state_q == ST_WAIT_DATA) && mem_readdatavalid;

   assign mem_addr = cur_q;
   assign mem_read = read_q;
   assign busy     = busy_q;
   assign done     = done_q;

   // Next-state and next-output logic for the memory side of the dump.
   // NOTE: every signal gets its default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      end_d   = end_q;
      hex_d   = hex_q;
      line_d  = line_q;
      read_d  = read_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_READ;
               cur_d   = start_addr;
               end_d   = end_addr;
               hex_d   = mode_hex;
               line_d  = '0;
               read_d  = 1'b1;
               busy_d  = 1'b1;
            end
         end
         ST_READ: begin
            if (!mem_waitrequest) begin
               read_d  = 1'b0;
               state_d = ST_WAIT_DATA;
            end
         end
         ST_WAIT_DATA: begin
            if (mem_readdatavalid) state_d = ST_EMIT;
         end
         ST_EMIT: begin
            if (word_done) begin
               if (is_last) begin
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_READ;
                  cur_d   = cur_q + 1'b1;
                  line_d  = (line_q == LC_LAST) ? '0 : line_q + 1'b1;
                  read_d  = 1'b1;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and registered-output update.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cur_q   <= '0;
         end_q   <= '0;
         hex_q   <= 1'b0;
         line_q  <= '0;
         read_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         end_q   <= end_d;
         hex_q   <= hex_d;
         line_q  <= line_d;
         read_q  <= read_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   dump_formatter #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .BIG_ENDIAN (BIG_ENDIAN)
   ) u_fmt (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .word       (mem_data),
      .addr       (cur_q),
      .hex        (hex_q),
      .prefix     (line_q == '0),
      .eol        ((line_q == LC_LAST) || is_last),
      .uart_ready (uart_ready),
      .uart_valid (uart_valid),
      .uart_data  (uart_data),
      .word_done  (word_done)
   );

endmodule

// File: doc/uart_mem_dump_fmt.md
# uart_mem_dump_fmt

Parametrised successor to the UART memory dumper: on a start pulse it reads an inclusive address range from an Avalon-MM-style memory port and streams the contents as bytes to a valid/ready UART transmitter. It supports configurable address/data widths, selectable byte order, and a runtime choice between raw binary output and human-readable ASCII hex lines with address prefixes. It sits between the on-chip memory (e.g. UFM) and `uart_tx`.

## Interface
- `ADDR_W`, 17, memory word address width
- `DATA_W`, 32, memory word width; multiple of 8, 8..64
- `BIG_ENDIAN`, 1, binary mode byte order: 1 = MSB byte first, 0 = LSB byte first
- `WORDS_PER_LINE`, 4, hex mode words per output line, ≥1
- `clk` in 1: single clock; everything is synchronous to its rising edge
- `reset` in 1: synchronous, active-high reset
- `start` in 1: one-cycle request to begin a dump; ignored while `busy`
- `start_addr` in ADDR_W: first address, latched on accepted `start`
- `end_addr` in ADDR_W: last address (inclusive), latched on accepted `start`
- `mode_hex` in 1: 0 = binary, 1 = ASCII hex; latched on accepted `start`
- `busy` out 1: high from the cycle after accepted `start` until `done`
- `done` out 1: one-cycle pulse after the final byte transfer
- `mem_addr` out ADDR_W: read address
- `mem_read` out 1: read request
- `mem_data` in DATA_W: read data, valid with `mem_readdatavalid`
- `mem_waitrequest` in 1: stall; hold request while high
- `mem_readdatavalid` in 1: read data valid
- `uart_valid` out 1: byte available
- `uart_ready` in 1: transmitter accepts byte
- `uart_data` out 8: byte to send

## Operation
- States: IDLE → READ → WAIT_DATA → EMIT → (READ | DONE) → IDLE.
- IDLE: on `start`, latch `start_addr`, `end_addr`, `mode_hex`; clear the word-in-line counter; go to READ.
- READ: drive `mem_read=1` and `mem_addr=cur`. The request is accepted in the cycle `mem_waitrequest=0`; then go to WAIT_DATA. Address and read stay stable while stalled.
- WAIT_DATA: on `mem_readdatavalid`, capture `mem_data` and go to EMIT. `readdatavalid` outside WAIT_DATA is ignored.
- EMIT, binary mode: DATA_W/8 bytes in `BIG_ENDIAN` order.
- EMIT, hex mode, sequence per word:
  - If the word-in-line counter is 0: ceil(ADDR_W/4) address digits, then `:` (0x3A), then space (0x20).
  - Then DATA_W/4 data digits, MSB nibble first.
  - Then CR LF (0x0D 0x0A) if the line is full or this is the last word; otherwise a space.
  - Digits are uppercase `0-9` `A-F`. The address is zero-extended to a nibble boundary.
- After the last byte of a word: if `cur==end_addr`, go to DONE. Otherwise `cur` increments modulo 2^ADDR_W (so `end_addr < start_addr` wraps through max), the line counter advances modulo `WORDS_PER_LINE`, and the state returns to READ.
- DONE: `done=1` for one cycle, `busy=0`, then IDLE.
- `start` while busy: ignored, with no effect on the latched values.

## Timing
- All outputs are registered. Reset values: `busy`, `done`, `mem_read`, `uart_valid` = 0; `mem_addr`, `uart_data` = 0.
- Accepted `start` at cycle 0 → `busy=1` and `mem_read=1` at cycle 1.
- `mem_readdatavalid` at cycle k → `uart_valid=1` with the first byte at k+1.
- UART handshake:
  - A transfer occurs on a cycle with `uart_valid && uart_ready`.
  - `uart_data` is held stable while `uart_valid && !uart_ready`.
  - The next byte may be presented in the cycle after a transfer, with `uart_valid` held high. This gives back-to-back throughput of 1 byte/cycle.
- `uart_valid` deasserts during READ/WAIT_DATA.
- Final transfer at cycle n → `done=1`, `busy=0` at n+1.
- `reset` asserted at any point returns to IDLE with reset output values on the next edge. This includes mid-byte with `uart_valid` high; the dropped byte is acceptable.

## Structure
- Package `uart_dump_pkg`:
  - State enum.
  - ASCII constants: CR, LF, colon, space.
  - Function `nibble_to_ascii`.
  - Localparams `ADDR_DIGITS`, `DATA_DIGITS`, `DATA_BYTES` as functions of the parameters.
- Natural sub-module `dump_formatter`: takes the captured word and address, runs the byte/digit sequencing counter, and drives the valid/ready byte output. It raises `word_done` to the top FSM, which owns the memory side.

## Test plan
- Binary, `BIG_ENDIAN=1`, range 0..1, memory returns 0xFE000021, `uart_ready=1` → bytes FE 00 00 21 FE 00 00 21, 8 transfers, then a single `done` pulse.
- Hex, range 0x00010..0x00011, ADDR_W=17 → ASCII "00010: FE000021 FE000021\r\n" (26 bytes).
- `mem_waitrequest` high for 3 cycles on the first read → `mem_read`/`mem_addr` stable for 4 cycles, exactly one read issued per word.
- `uart_ready` low for 10 cycles during the third byte → `uart_data` unchanged throughout, no byte lost or duplicated.
- Wrap, range 0x1FFFF..0x00000 → reads issued at 0x1FFFF then 0x00000, then `done`.
- `start` pulsed while busy → ignored. `reset` mid-EMIT → next cycle all outputs are 0 and the FSM is in IDLE; a new `start` then dumps normally.
